// File: rtl/std_fifo_burst_reader.sv
// Burst read engine for a first-word-fall-through std_fifo: pops up to BURST_LEN words per burst onto a
// registered valid/ready stream with a last-beat marker. Define STD_FIFO_BURST_READER_TIMEOUT_EN to add the idle timeout start.
module std_fifo_burst_reader #(
    parameter int  WIDTH       = 8,
    parameter type TYPE        = logic [WIDTH-1:0],
    parameter int  FIFO_DEPTH  = 8,
    parameter int  BURST_LEN   = 4,
    parameter int  TIMEOUT     = 16,
    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_flush,
    input  logic                   i_fifo_empty,
    input  logic [COUNT_WIDTH-1:0] i_fifo_word_count,
    input  TYPE                    i_fifo_data,
    output logic                   o_fifo_pop,
    output logic                   o_valid,
    input  logic                   i_ready,
    output TYPE                    o_data,
    output logic                   o_last,
    output logic                   o_busy
);

    // Stream handshake: a beat transfers on any rising edge where o_valid and i_ready are both high;
    // while o_valid is high and i_ready low, o_data and o_last are held unchanged.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] BURST_LEN_C = COUNT_WIDTH'(BURST_LEN);
    localparam logic [COUNT_WIDTH-1:0] ONE_C       = COUNT_WIDTH'(1);

    if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH || TIMEOUT < 1) begin : g_bad_params
        $error("std_fifo_burst_reader: BURST_LEN must be 1..FIFO_DEPTH and TIMEOUT >= 1");
    end

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_WIDTH-1:0] beat_cnt;
    logic [COUNT_WIDTH-1:0] burst_len;
    logic [COUNT_WIDTH-1:0] start_len;
    logic                   start;
    logic                   fifo_pop;
    logic                   timeout_hit;

`ifdef STD_FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            tmo_cnt <= '0;
        end else if (state != IDLE || i_fifo_empty || start) begin
            tmo_cnt <= '0;
        end else if (i_fifo_word_count < BURST_LEN_C && tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // A flush with a non-empty FIFO always yields at least one beat.
    always_comb begin
        if (i_fifo_word_count >= BURST_LEN_C) begin
            start_len = BURST_LEN_C;
        end else if (i_fifo_word_count == '0) begin
            start_len = ONE_C;
        end else begin
            start_len = i_fifo_word_count;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                start = !i_fifo_empty && (i_fifo_word_count >= BURST_LEN_C || i_flush || timeout_hit);
                if (start) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                fifo_pop = !i_fifo_empty && (!o_valid || i_ready);
                if (fifo_pop && beat_cnt == burst_len - ONE_C) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!o_valid || (i_ready && o_last)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (i_rst || i_clear) begin
            state_next = IDLE;
            fifo_pop   = 1'b0;
            start      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_last    <= 1'b0;
            beat_cnt  <= '0;
            burst_len <= '0;
        end else if (i_clear) begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            beat_cnt  <= '0;
            burst_len <= '0;
        end else begin
            if (start) begin
                burst_len <= start_len;
                beat_cnt  <= '0;
            end
            if (fifo_pop) begin
                o_data   <= i_fifo_data;
                o_valid  <= 1'b1;
                o_last   <= (beat_cnt == burst_len - ONE_C);
                beat_cnt <= beat_cnt + ONE_C;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

    assign o_fifo_pop = fifo_pop;
    assign o_busy     = (state != IDLE);

endmodule
